// File: rtl/pwm_meas_pkg.sv
// Shared types and constants for the PWM duty meter.
// Holds the measurement and divider state encodings.
package pwm_meas_pkg;

    localparam int PCT_SCALE = 100;
    localparam int DUTY_W    = 7;

    typedef enum logic {
        IDLE,
        MEASURE
    } meas_state_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake with a synchronous abort.
module seq_divider
    import pwm_meas_pkg::*;
#(
    parameter int NUM_W = 17,
    parameter int DEN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             abort,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient,
    output logic [DEN_W-1:0] remainder
);
    localparam int IT_W = $clog2(NUM_W);
    localparam logic [IT_W-1:0] LAST_IT = IT_W'(NUM_W - 1);

    div_state_e       st_q;
    div_state_e       st_d;
    logic [NUM_W-1:0] quo_q;
    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    logic [IT_W-1:0]  it_q;
    logic [DEN_W:0]   trial;
    logic [DEN_W:0]   diff;
    logic             ge;
    logic             load;

    // Numerator bits shift out the top while quotient bits fill the bottom.
    assign trial = {rem_q, quo_q[NUM_W-1]};
    assign diff  = trial - {1'b0, den_q};
    assign ge    = trial >= {1'b0, den_q};
    assign load  = (st_q == DIV_IDLE) && (st_d == DIV_RUN);

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            DIV_IDLE: if (start) st_d = DIV_RUN;
            DIV_RUN:  if (it_q == LAST_IT) st_d = DIV_DONE;
            DIV_DONE: st_d = DIV_IDLE;
            default:  st_d = DIV_IDLE;
        endcase
        if (abort) st_d = DIV_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st_q <= DIV_IDLE;
        else     st_q <= st_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            it_q  <= '0;
        end else if (load) begin
            quo_q <= dividend;
            rem_q <= '0;
            den_q <= divisor;
            it_q  <= '0;
        end else if (st_q == DIV_RUN) begin
            quo_q <= {quo_q[NUM_W-2:0], ge};
            rem_q <= ge ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
            it_q  <= it_q + 1'b1;
        end
    end

    assign busy      = (st_q != DIV_IDLE);
    assign done      = (st_q == DIV_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures period and duty of an asynchronous PWM input.
// Each accepted period feeds the sequential divider; results strobe meas_valid.
module pwm_duty_meter
    import pwm_meas_pkg::*;
#(
    parameter int MAX_PERIOD  = 1000,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = $clog2(MAX_PERIOD + 1)
) (
    input  logic              org_clk,
    input  logic              sys_rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic [CNT_W-1:0]  period,
    output logic              meas_valid,
    output logic              timeout,
    output logic              overrun
);
    localparam int NUM_W = CNT_W + DUTY_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   pwm_s;
    logic                   pwm_s_d;
    logic                   rise;

    meas_state_e st_q;
    meas_state_e st_d;
    logic        tmo;
    logic        sample;

    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] p_lat;

    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [NUM_W-1:0]  dividend;
    logic [NUM_W-1:0]  quo;
    logic [CNT_W-1:0]  unused_rem;
    logic [DUTY_W-1:0] duty_div;

    // fill_q keeps reset-cleared flops from posing as a real low level.
    always_ff @(posedge org_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_q  <= '0;
            fill_q  <= '0;
            pwm_s_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            fill_q  <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            pwm_s_d <= pwm_s;
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1];
    assign rise  = pwm_s & ~pwm_s_d & fill_q[SYNC_STAGES];

    always_comb begin
        st_d = st_q;
        tmo  = 1'b0;
        unique case (st_q)
            IDLE: if (rise) st_d = MEASURE;
            MEASURE: begin
                if (!rise && per_cnt == MAX_CNT) begin
                    st_d = IDLE;
                    tmo  = 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge org_clk or posedge sys_rst) begin
        if (sys_rst) st_q <= IDLE;
        else         st_q <= st_d;
    end

    assign sample    = rise && (st_q == MEASURE);
    assign div_start = sample && !div_busy;

    always_ff @(posedge org_clk or posedge sys_rst) begin
        if (sys_rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            p_lat   <= '0;
        end else begin
            if (tmo) begin
                per_cnt <= '0;
                hi_cnt  <= '0;
            end else if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
            end else if (st_q == MEASURE) begin
                if (per_cnt != MAX_CNT) per_cnt <= per_cnt + 1'b1;
                if (pwm_s && hi_cnt != MAX_CNT) hi_cnt <= hi_cnt + 1'b1;
            end
            if (div_start) p_lat <= per_cnt;
        end
    end

    assign dividend = NUM_W'(hi_cnt) * NUM_W'(PCT_SCALE);

    seq_divider #(
        .NUM_W(NUM_W),
        .DEN_W(CNT_W)
    ) u_div (
        .clk      (org_clk),
        .rst      (sys_rst),
        .abort    (tmo),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (per_cnt),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo),
        .remainder(unused_rem)
    );

    assign duty_div = (quo > NUM_W'(PCT_SCALE)) ? DUTY_W'(PCT_SCALE)
                                                : quo[DUTY_W-1:0];

    // A timeout outranks a finishing divide; its result is dropped.
    always_ff @(posedge org_clk or posedge sys_rst) begin
        if (sys_rst) begin
            duty_cycle <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            overrun    <= sample && div_busy;
            if (tmo) begin
                duty_cycle <= pwm_s ? DUTY_W'(PCT_SCALE) : '0;
                period     <= '0;
                timeout    <= 1'b1;
                meas_valid <= 1'b1;
            end else if (div_done) begin
                duty_cycle <= duty_div;
                period     <= p_lat;
                timeout    <= 1'b0;
                meas_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
Measures an incoming PWM waveform and reports its period in org_clk cycles and its duty cycle as an integer percentage from 0 to 100. It is the receive-side counterpart of the team's PWM generator and closes the loop in loopback self-test. The duty cycle is computed with a multi-cycle sequential divider, so no combinational divide is needed. Each completed measurement is flagged by a one-cycle valid strobe.

Parameters:
MAX_PERIOD, 1000, longest legal PWM period in org_clk cycles; reaching it without a rising edge is a timeout.
SYNC_STAGES, 2, flip-flop synchronizer depth on pwm_in (minimum 2).
CNT_W, $clog2(MAX_PERIOD+1), width of the period and high-time counters (derived; do not override).

Ports:
org_clk  in  1  system clock.
sys_rst  in  1  asynchronous reset, active-high.
pwm_in  in  1  asynchronous PWM input.
duty_cycle  out  7  last measured duty in percent, 0..100.
period  out  CNT_W  last measured period in org_clk cycles.
meas_valid  out  1  one-cycle strobe; duty_cycle and period were updated this cycle.
timeout  out  1  high while the last result came from a timeout (input stuck).
overrun  out  1  one-cycle strobe; a period completed while the divider was busy, and that sample was dropped.

Behaviour:
- Reset (async, sys_rst=1): all outputs 0, synchronizer cleared, FSM to IDLE, counters 0.
- Input path: SYNC_STAGES-flop synchronizer feeds pwm_s. A rising edge (rise) is pwm_s=1 with the previous pwm_s=0.
- IDLE: wait for rise. On rise, go to MEASURE with per_cnt=1 and hi_cnt=1.
- MEASURE, every cycle without rise: per_cnt+1, and hi_cnt+1 if pwm_s=1.
- MEASURE, on rise:
  - Latch P=per_cnt and H=hi_cnt.
  - Restart per_cnt=1 and hi_cnt=1. Measurement is continuous and back-to-back.
  - Start the divider if it is idle. Otherwise pulse overrun and discard P/H.
- Period definition: the cycle count from one rise to the next, inclusive of the first and exclusive of the second. A 100-cycle PWM gives P=100.
- Divider: computes floor(H*100 / P).
  - Numerator width NUM_W = CNT_W+7. Restoring algorithm, one quotient bit per cycle, NUM_W iterations.
  - Clamp the quotient to 100.
- Latency: meas_valid asserts exactly NUM_W+2 org_clk cycles after the cycle in which rise is seen, excluding synchronizer delay.
  - On that cycle, duty_cycle, period=P, and timeout=0 update together.
- Timeout: in MEASURE, if per_cnt reaches MAX_PERIOD with no rise:
  - duty_cycle = 100 if pwm_s=1, else 0; period = 0; timeout = 1; pulse meas_valid.
  - Return to IDLE. If the divider is in flight, abort it; its result is never published.
  - timeout stays high until the next normal result.
- In IDLE after reset, a constant input never produces meas_valid. Timeout is reachable only from MEASURE.
- Outputs hold between updates. meas_valid and overrun are never high for more than 1 cycle.
- Simultaneous events: if rise occurs in the same cycle per_cnt reaches MAX_PERIOD, rise wins (normal sample, P=MAX_PERIOD).
- Reset mid-divide: abort immediately, outputs to 0, no meas_valid.
- All counters saturate at MAX_PERIOD; no wrap.

Decomposition:
- pwm_meas_pkg holds:
  - FSM state typedef: IDLE, MEASURE.
  - Divider state typedef: DIV_IDLE, DIV_RUN, DIV_DONE.
  - Constant PCT_SCALE = 100.
- One sub-module: seq_divider.
  - Parameterized unsigned restoring divider.
  - start/busy/done handshake, quotient and remainder outputs.
  - Async active-high reset plus a synchronous abort.
  - Reusable elsewhere.

Test Plan:
- Drive pwm_in from the PWM generator with N=100 and duty 25 -> meas_valid every 100 cycles; duty_cycle=25, period=100, timeout=0, no overrun.
- Hand-driven period 3, high 1 -> duty_cycle=33 (floor), period=3. Period 7, high 6 -> duty_cycle=85.
- Generator duty=100 (pwm_in constant high after one rise) -> at per_cnt=MAX_PERIOD: meas_valid, duty_cycle=100, period=0, timeout=1. Then a rise followed by 50/100 pattern -> duty_cycle=50, timeout=0.
- Period shorter than NUM_W+2 (e.g. 4-cycle square wave) -> overrun pulses on the skipped edges. Published results are always duty_cycle=50, period=4.
- Assert sys_rst during DIV_RUN -> all outputs 0 that cycle (async), no meas_valid after release until a full period is measured.
- Rise coincident with per_cnt=MAX_PERIOD -> normal result with period=MAX_PERIOD, timeout=0.
